btn_conditioner: RTL

Front-end conditioner that turns a raw, asynchronous, bouncing push-button into the clean single-cycle `btn` strobe consumed by the `FSM` LED-pattern block. It synchronises the pad input, debounces press and release, and emits a press strobe, a long-press strobe and optional auto-repeat strobes. It sits between the board button pad and `FSM.btn`, in the same clock domain as `FSM`.

---
 rtl/btn_conditioner.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/btn_conditioner.sv
// Purpose: synchronise, debounce and strobe-encode a bouncing push-button pad for the FSM block.
// Latency: press strobe DEBOUNCE_CYCLES+2 edges after the first high sample; release likewise.
// Backpressure: none; strobes are fire-and-forget single-cycle pulses, the consumer must take them.
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset, dominant over everything
//   btn_raw     raw asynchronous pad level, active-high, may bounce
//   btn         one-cycle press strobe plus auto-repeat strobes (to FSM.btn)
//   long_press  one-cycle strobe when a hold reaches LONG_CYCLES
//   released    one-cycle strobe on an accepted release
//   pressed     debounced level, high from press acceptance to release acceptance
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn,
  output logic long_press,
  output logic released,
  output logic pressed
);

  // Counter widths; a floor of one bit keeps degenerate parameters legal.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1)     ? $clog2(LONG_CYCLES)     : 1;
  localparam int RW = (REPEAT_CYCLES > 1)   ? $clog2(REPEAT_CYCLES)   : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_MAX  = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Two-flop synchroniser; only s2 is allowed to reach the state machine.
  logic s1;
  logic s2;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [HW-1:0] hold;
  logic [HW-1:0] hold_nxt;
  logic [RW-1:0] rep;
  logic [RW-1:0] rep_nxt;
  logic          long_fired;
  logic          long_fired_nxt;

  logic          btn_nxt;
  logic          long_press_nxt;
  logic          released_nxt;
  logic          pressed_nxt;

  // Set on any edge where the button is seen high while a press is owned,
  // which advances the hold / repeat timeline.
  logic          run_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      rep        <= '0;
      long_fired <= 1'b0;
      btn        <= 1'b0;
      long_press <= 1'b0;
      released   <= 1'b0;
      pressed    <= 1'b0;
    end else begin
      s1         <= btn_raw;
      s2         <= s1;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hold       <= hold_nxt;
      rep        <= rep_nxt;
      long_fired <= long_fired_nxt;
      btn        <= btn_nxt;
      long_press <= long_press_nxt;
      released   <= released_nxt;
      pressed    <= pressed_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    hold_nxt       = hold;
    rep_nxt        = rep;
    long_fired_nxt = long_fired;
    btn_nxt        = 1'b0;
    long_press_nxt = 1'b0;
    released_nxt   = 1'b0;
    pressed_nxt    = pressed;
    run_hold       = 1'b0;

    case (state)
      IDLE: begin
        if (s2) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s2) begin
          // Too short to be a press: drop it silently.
          state_nxt = IDLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = HELD;
          btn_nxt     = 1'b1;
          pressed_nxt = 1'b1;
          hold_nxt    = '0;
          rep_nxt     = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      HELD: begin
        if (!s2) begin
          // Possible release: hold, rep and long_fired freeze until it is
          // either accepted or rejected as a bounce.
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = '0;
        end else begin
          run_hold = 1'b1;
        end
      end

      RELEASE_WAIT: begin
        if (s2) begin
          // Bounce rejected. The button is already high again on this edge,
          // so the hold timeline resumes here; a glitch therefore delays
          // long/repeat strobes by exactly the number of low samples.
          state_nxt = HELD;
          run_hold  = 1'b1;
        end else if (cnt == CNT_MAX) begin
          state_nxt      = IDLE;
          pressed_nxt    = 1'b0;
          released_nxt   = 1'b1;
          long_fired_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (run_hold) begin
      if (!long_fired) begin
        // hold saturates at HOLD_MAX; the long strobe marks the saturation.
        if (hold != HOLD_MAX) begin
          hold_nxt = hold + HW'(1);
        end else begin
          long_press_nxt = 1'b1;
          long_fired_nxt = 1'b1;
          rep_nxt        = '0;
        end
      end else if (REPEAT_EN) begin
        // rep starts from 0 on the long-press edge, so the first repeat
        // lands REPEAT_CYCLES after long_press and never coincides with it.
        if (rep == REP_MAX) begin
          btn_nxt = 1'b1;
          rep_nxt = '0;
        end else begin
          rep_nxt = rep + RW'(1);
        end
      end
    end
  end

endmodule
